// File: rtl/spi_target.sv
// SPI mode-0 target that turns write bursts into register-file load strobes
// and serves reads from an internal mirror of everything it has written.
module spi_target #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       s_sclk,
    input  logic       s_cs,
    input  logic       s_mosi,
    output logic       s_miso,
    output logic       load,
    output logic [2:0] addr,
    output logic [7:0] data
);

    typedef enum logic [1:0] {IDLE, CMD, WR, RD} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sclkSync_q, csSync_q, mosiSync_q;
    logic                   sclkPrev_q, csPrev_q;
    logic [2:0]             cnt_q, cnt_d;
    logic [7:0]             rx_q, rx_d;
    logic [7:0]             tx_q, tx_d;
    logic [2:0]             ptr_q, ptr_d;
    logic                   miso_q, miso_d;
    logic                   load_q, load_d;
    logic [2:0]             addr_q, addr_d;
    logic [7:0]             data_q, data_d;
    logic [7:0]             mirror_q [8];
    logic                   memWe;

    logic       sclk, cs, mosi;
    logic       sclkRise, sclkFall, csFall, byteDone;
    logic [7:0] rxByte;

    // Synchronizers idle at the bus rest levels so reset looks like "not selected".
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sclkSync_q <= '0;
            csSync_q   <= '1;
            mosiSync_q <= '0;
            sclkPrev_q <= 1'b0;
            csPrev_q   <= 1'b1;
        end else begin
            sclkSync_q <= {sclkSync_q[SYNC_STAGES-2:0], s_sclk};
            csSync_q   <= {csSync_q[SYNC_STAGES-2:0], s_cs};
            mosiSync_q <= {mosiSync_q[SYNC_STAGES-2:0], s_mosi};
            sclkPrev_q <= sclkSync_q[SYNC_STAGES-1];
            csPrev_q   <= csSync_q[SYNC_STAGES-1];
        end
    end

    assign sclk     = sclkSync_q[SYNC_STAGES-1];
    assign cs       = csSync_q[SYNC_STAGES-1];
    assign mosi     = mosiSync_q[SYNC_STAGES-1];
    assign sclkRise = sclk & ~sclkPrev_q;
    assign sclkFall = ~sclk & sclkPrev_q;
    assign csFall   = ~cs & csPrev_q;
    assign rxByte   = {rx_q[6:0], mosi};
    assign byteDone = ~cs & sclkRise & (cnt_q == 3'd7) & (state_q != IDLE);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (cs) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (csFall) state_d = CMD;
                CMD:     if (byteDone) state_d = rxByte[7] ? WR : RD;
                default: state_d = state_q;
            endcase
        end
    end

    // A deselected bus (cs high) always wins over a coincident sclk edge.
    always_comb begin
        cnt_d  = cnt_q;
        rx_d   = rx_q;
        tx_d   = tx_q;
        ptr_d  = ptr_q;
        miso_d = miso_q;
        load_d = 1'b0;
        addr_d = addr_q;
        data_d = data_q;
        memWe  = 1'b0;
        if (cs) begin
            cnt_d  = 3'd0;
            rx_d   = 8'h00;
            tx_d   = 8'h00;
            miso_d = 1'b0;
        end else if (state_q != IDLE) begin
            if (sclkRise) begin
                cnt_d = cnt_q + 3'd1;
                rx_d  = rxByte;
            end
            if (sclkFall) begin
                miso_d = tx_q[7];
                tx_d   = {tx_q[6:0], 1'b0};
            end
            if (byteDone) begin
                case (state_q)
                    CMD: begin
                        ptr_d = rxByte[2:0];
                        if (!rxByte[7]) begin
                            tx_d  = mirror_q[rxByte[2:0]];
                            ptr_d = rxByte[2:0] + 3'd1;
                        end
                    end
                    WR: begin
                        load_d = 1'b1;
                        addr_d = ptr_q;
                        data_d = rxByte;
                        memWe  = 1'b1;
                        ptr_d  = ptr_q + 3'd1;
                    end
                    RD: begin
                        tx_d  = mirror_q[ptr_q];
                        ptr_d = ptr_q + 3'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q  <= 3'd0;
            rx_q   <= 8'h00;
            tx_q   <= 8'h00;
            ptr_q  <= 3'd0;
            miso_q <= 1'b0;
            load_q <= 1'b0;
            addr_q <= 3'd0;
            data_q <= 8'h00;
        end else begin
            cnt_q  <= cnt_d;
            rx_q   <= rx_d;
            tx_q   <= tx_d;
            ptr_q  <= ptr_d;
            miso_q <= miso_d;
            load_q <= load_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < 8; i++) mirror_q[i] <= 8'h00;
        end else if (memWe) begin
            mirror_q[ptr_q] <= rxByte;
        end
    end

    assign s_miso = miso_q & ~cs;
    assign load   = load_q;
    assign addr   = addr_q;
    assign data   = data_q;

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: drives mode-0 SPI at clk/8 and checks
// load strobes, readback data and abort/reset behaviour.
module tb_spi_target;

    logic       clk;
    logic       n_rst;
    logic       s_sclk;
    logic       s_cs;
    logic       s_mosi;
    logic       s_miso;
    logic       load;
    logic [2:0] addr;
    logic [7:0] data;

    int testsRun;
    int testsFailed;
    logic [10:0] loadQ [$];

    spi_target #(.SYNC_STAGES(2)) dut (
        .clk    (clk),
        .n_rst  (n_rst),
        .s_sclk (s_sclk),
        .s_cs   (s_cs),
        .s_mosi (s_mosi),
        .s_miso (s_miso),
        .load   (load),
        .addr   (addr),
        .data   (data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every load pulse is logged with its address and data, sampled mid-cycle.
    always @(negedge clk) begin
        if (load === 1'b1) loadQ.push_back({addr, data});
    end

    task automatic waitClk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic csLow();
        @(negedge clk);
        s_cs = 1'b0;
        waitClk(6);
    endtask

    task automatic csHigh();
        waitClk(6);
        s_cs = 1'b1;
        waitClk(10);
    endtask

    task automatic spiBits(input logic [7:0] txByte, input int nBits, output logic [7:0] rxByte);
        rxByte = 8'h00;
        for (int i = 7; i > 7 - nBits; i--) begin
            s_mosi = txByte[i];
            waitClk(4);
            s_sclk = 1'b1;
            rxByte[i] = s_miso;
            waitClk(4);
            s_sclk = 1'b0;
        end
    endtask

    task automatic spiByte(input logic [7:0] txByte, output logic [7:0] rxByte);
        spiBits(txByte, 8, rxByte);
    endtask

    task automatic checkVal(input string name, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        waitClk(3);
        testsRun++;
        if (load !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_load: got %b, expected 0", load); end
        testsRun++;
        if (addr !== 3'd0) begin testsFailed++; $display("[TB] FAIL reset_addr: got %0h, expected 0", addr); end
        testsRun++;
        if (data !== 8'h00) begin testsFailed++; $display("[TB] FAIL reset_data: got %0h, expected 0", data); end
        testsRun++;
        if (s_miso !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_miso: got %b, expected 0", s_miso); end
        n_rst = 1'b1;
        waitClk(5);
    endtask

    task automatic test_single_write();
        logic [7:0] r;
        loadQ.delete();
        csLow();
        spiByte(8'h83, r);
        spiByte(8'hA5, r);
        csHigh();
        testsRun++;
        if (loadQ.size() !== 1) begin
            testsFailed++;
            $display("[TB] FAIL single_count: got %0d loads, expected 1", loadQ.size());
        end else begin
            testsRun++;
            if (loadQ[0] !== {3'd3, 8'hA5}) begin
                testsFailed++;
                $display("[TB] FAIL single_load: got %0h, expected %0h", loadQ[0], {3'd3, 8'hA5});
            end
        end
        testsRun++;
        if (addr !== 3'd3 || data !== 8'hA5) begin
            testsFailed++;
            $display("[TB] FAIL single_hold: got addr %0h data %0h, expected 3 a5", addr, data);
        end
        testsRun++;
        if (s_miso !== 1'b0) begin testsFailed++; $display("[TB] FAIL idle_miso: got %b, expected 0", s_miso); end
    endtask

    task automatic test_burst_wrap();
        logic [7:0] r;
        loadQ.delete();
        csLow();
        spiByte(8'h87, r);
        spiByte(8'h11, r);
        spiByte(8'h22, r);
        csHigh();
        testsRun++;
        if (loadQ.size() !== 2) begin
            testsFailed++;
            $display("[TB] FAIL wrap_count: got %0d loads, expected 2", loadQ.size());
        end else begin
            testsRun++;
            if (loadQ[0] !== {3'd7, 8'h11}) begin
                testsFailed++;
                $display("[TB] FAIL wrap_first: got %0h, expected %0h", loadQ[0], {3'd7, 8'h11});
            end
            testsRun++;
            if (loadQ[1] !== {3'd0, 8'h22}) begin
                testsFailed++;
                $display("[TB] FAIL wrap_second: got %0h, expected %0h", loadQ[1], {3'd0, 8'h22});
            end
        end
    endtask

    task automatic test_readback();
        logic [7:0] r;
        loadQ.delete();
        csLow();
        spiByte(8'h03, r);
        spiByte(8'h00, r);
        testsRun++;
        if (r !== 8'hA5) begin testsFailed++; $display("[TB] FAIL read_addr3: got %0h, expected a5", r); end
        spiByte(8'h00, r);
        testsRun++;
        if (r !== 8'h00) begin testsFailed++; $display("[TB] FAIL read_addr4: got %0h, expected 00", r); end
        csHigh();
        testsRun++;
        if (loadQ.size() !== 0) begin testsFailed++; $display("[TB] FAIL read_noload: got %0d loads, expected 0", loadQ.size()); end
    endtask

    task automatic test_abort();
        logic [7:0] r;
        loadQ.delete();
        csLow();
        spiByte(8'h82, r);
        spiBits(8'hFF, 5, r);
        csHigh();
        csLow();
        spiByte(8'h85, r);
        csHigh();
        testsRun++;
        if (loadQ.size() !== 0) begin testsFailed++; $display("[TB] FAIL abort_noload: got %0d loads, expected 0", loadQ.size()); end
        csLow();
        spiByte(8'h02, r);
        spiByte(8'h00, r);
        csHigh();
        testsRun++;
        if (r !== 8'h00) begin testsFailed++; $display("[TB] FAIL abort_read: got %0h, expected 00", r); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] r;
        loadQ.delete();
        csLow();
        spiByte(8'h81, r);
        spiByte(8'h5A, r);
        csHigh();
        testsRun++;
        if (loadQ.size() !== 1) begin testsFailed++; $display("[TB] FAIL rst_prewrite: got %0d loads, expected 1", loadQ.size()); end
        loadQ.delete();
        csLow();
        spiByte(8'h81, r);
        spiBits(8'hFF, 3, r);
        s_mosi = 1'b1;
        waitClk(4);
        s_sclk = 1'b1;
        waitClk(1);
        n_rst = 1'b0;
        waitClk(2);
        testsRun++;
        if (load !== 1'b0) begin testsFailed++; $display("[TB] FAIL rst_mid_load: got %b, expected 0", load); end
        testsRun++;
        if (s_miso !== 1'b0) begin testsFailed++; $display("[TB] FAIL rst_mid_miso: got %b, expected 0", s_miso); end
        s_sclk = 1'b0;
        s_cs   = 1'b1;
        waitClk(2);
        n_rst = 1'b1;
        waitClk(10);
        testsRun++;
        if (loadQ.size() !== 0) begin testsFailed++; $display("[TB] FAIL rst_mid_noload: got %0d loads, expected 0", loadQ.size()); end
        csLow();
        spiByte(8'h01, r);
        spiByte(8'h00, r);
        csHigh();
        testsRun++;
        if (r !== 8'h00) begin testsFailed++; $display("[TB] FAIL rst_read_addr1: got %0h, expected 00", r); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] r;
        int bad;
        loadQ.delete();
        csLow();
        spiByte(8'h80, r);
        for (int i = 0; i < 16; i++) spiByte(8'h10 + 8'(i), r);
        csHigh();
        testsRun++;
        if (loadQ.size() !== 16) begin
            testsFailed++;
            $display("[TB] FAIL burst_count: got %0d loads, expected 16", loadQ.size());
        end else begin
            bad = 0;
            for (int i = 0; i < 16; i++) begin
                if (loadQ[i] !== {3'(i % 8), 8'h10 + 8'(i)}) begin
                    bad++;
                    $display("[TB] FAIL burst_load%0d: got %0h, expected %0h", i, loadQ[i], {3'(i % 8), 8'h10 + 8'(i)});
                end
            end
            testsRun++;
            if (bad != 0) testsFailed++;
        end
        csLow();
        spiByte(8'h00, r);
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            spiByte(8'h00, r);
            if (r !== 8'h18 + 8'(k)) begin
                bad++;
                $display("[TB] FAIL burst_read%0d: got %0h, expected %0h", k, r, 8'h18 + 8'(k));
            end
        end
        csHigh();
        testsRun++;
        if (bad != 0) testsFailed++;
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        n_rst  = 1'b0;
        s_sclk = 1'b0;
        s_cs   = 1'b1;
        s_mosi = 1'b0;
        test_reset();
        test_single_write();
        test_burst_wrap();
        test_readback();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/spi_target.md
SPI_TARGET -- requirements
Module: spi_target

Interface
REQ-001 The module SHALL have one parameter: SYNC_STAGES, default 2, the number of input synchronizer flops on s_sclk, s_cs and s_mosi (minimum 2).
REQ-002 The module SHALL have the port clk, input, 1 bit, the system clock; it is the only clock.
REQ-003 The module SHALL have the port n_rst, input, 1 bit, the reset; it is asynchronous and active-low.
REQ-004 The module SHALL have the port s_sclk, input, 1 bit, the SPI clock from the external initiator (mode 0).
REQ-005 The module SHALL have the port s_cs, input, 1 bit, the chip select; active-low.
REQ-006 The module SHALL have the port s_mosi, input, 1 bit, the serial data from the initiator, MSB first.
REQ-007 The module SHALL have the port s_miso, output, 1 bit, the serial data to the initiator, MSB first; always driven, never tristated.
REQ-008 The module SHALL have the port load, output, 1 bit, the write strobe to the display register file.
REQ-009 The module SHALL have the port addr, output, 3 bits, the write address; it is valid when load=1.
REQ-010 The module SHALL have the port data, output, 8 bits, the write data; it is valid when load=1.

Function
REQ-011 All SPI inputs SHALL pass through SYNC_STAGES flops in the clk domain, and s_sclk edges SHALL be detected on the synchronized signal; s_sclk frequency SHALL be no greater than clk/8.
REQ-012 Mode 0 SHALL be used: s_mosi is sampled on the synchronized s_sclk rising edge, and s_miso updates on the synchronized s_sclk falling edge.
REQ-013 The module SHALL contain an internal 8x8 mirror register file; each mirror entry resets to 0x00 and is updated on every write.
REQ-014 The state machine SHALL use the states IDLE, CMD, WR and RD.
- IDLE->CMD when synchronized s_cs falls.
- Any state->IDLE when synchronized s_cs is high.
REQ-015 The first byte of a transaction SHALL be the command byte: bit7=1 selects write, bit7=0 selects read, bits[2:0] give the start address, and bits[6:3] are ignored.
REQ-016 On the 8th rising edge of the command byte, the FSM SHALL go CMD->WR or CMD->RD and load the 3-bit address pointer from bits[2:0].
REQ-017 In WR, each completed 8-bit byte SHALL:
- drive load=1 for exactly one clk cycle, in the cycle after the 8th rising edge is detected;
- drive addr=pointer and data=the received byte in that same cycle;
- write the mirror entry;
- increment the pointer.
REQ-018 In RD, the mirror entry at the pointer SHALL be loaded into the transmit shifter on the 8th rising edge of the preceding byte, and the pointer SHALL be incremented at that time.
REQ-019 In RD, s_miso SHALL present the shifter MSB from the first falling edge after the preceding byte, so that bit7 is valid before the next byte's first rising edge.
REQ-020 The pointer SHALL wrap from 7 to 0 in both WR and RD, and transactions of any length SHALL be supported.
REQ-021 The bit counter SHALL be 3 bits, wrap from 7 to 0 at each byte boundary, and be cleared whenever synchronized s_cs is high.
REQ-022 When synchronized s_cs is high, the following SHALL hold:
- s_miso=0;
- load=0;
- the partial receive byte is discarded.
REQ-023 If s_cs rises mid-byte, no load SHALL be issued and no mirror entry SHALL change.
REQ-024 If a synchronized s_cs rise and an s_sclk rising edge are detected in the same cycle, s_cs SHALL take priority and the bit SHALL be discarded.
REQ-025 A read SHALL return the mirror value as of the byte boundary where it is loaded into the shifter, including writes made in earlier transactions.
REQ-026 A command byte alone (s_cs raised right after it) SHALL produce no load.
REQ-027 addr and data SHALL hold their last values when load=0.

Reset
REQ-028 While n_rst=0, the following SHALL hold:
- FSM=IDLE;
- load=0, addr=0, data=0x00, s_miso=0;
- bit counter=0, pointer=0;
- all mirror entries=0x00;
- synchronizer flops reset to the idle level (s_cs=1, s_sclk=0, s_mosi=0).
REQ-029 Reset asserted mid-transaction SHALL abort the transaction without a load, and after release the module SHALL wait for a fresh s_cs falling edge.

Verification
REQ-030 The bench SHALL cover a single write: s_cs low, bytes 0x83, 0xA5, s_cs high -> exactly one load pulse with addr=3, data=0xA5.
REQ-031 The bench SHALL cover a burst write with wrap: bytes 0x87, 0x11, 0x22 -> load with addr=7, data=0x11, then load with addr=0, data=0x22.
REQ-032 The bench SHALL cover readback: after REQ-030, send 0x03 followed by 2 dummy bytes -> s_miso yields 0xA5 (addr 3) then 0x00 (addr 4), and load never asserts.
REQ-033 The bench SHALL cover an abort: send 0x82, then 5 bits of 0xFF, then s_cs high -> no load, and a subsequent read of addr 2 returns 0x00.
REQ-034 The bench SHALL cover reset mid-transfer: write 0x81, 0x5A; pulse n_rst low during a second write's 4th bit -> load=0, s_miso=0, and a read of addr 1 returns 0x00.
REQ-035 The bench SHALL cover a maximum-rate burst: s_sclk=clk/8 with a 16-byte write burst -> 16 load pulses with addr sequence 0..7,0..7 and no dropped or duplicated bits.
